// File: rtl/time_ctrl_pkg.sv
// Shared types and constants for the clock time-set controller.
package time_ctrl_pkg;

    localparam int unsigned FIELD_W = 6;

    localparam logic [FIELD_W-1:0] MAX_HOURS  = FIELD_W'(23);
    localparam logic [FIELD_W-1:0] MAX_MINSEC = FIELD_W'(59);

    typedef enum logic [2:0] {
        ST_RUN    = 3'd0,
        ST_SET_H  = 3'd1,
        ST_SET_M  = 3'd2,
        ST_SET_S  = 3'd3,
        ST_COMMIT = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        FIELD_NONE  = 2'd0,
        FIELD_HOURS = 2'd1,
        FIELD_MINS  = 2'd2,
        FIELD_SECS  = 2'd3
    } field_e;

    typedef struct packed {
        logic [FIELD_W-1:0] hours;
        logic [FIELD_W-1:0] mins;
        logic [FIELD_W-1:0] secs;
    } hms_t;

    // Increment with wrap; out-of-range captured values also fold back to zero.
    function automatic logic [FIELD_W-1:0] inc_wrap(input logic [FIELD_W-1:0] val,
                                                    input logic [FIELD_W-1:0] max_val);
        return (val >= max_val) ? '0 : val + FIELD_W'(1);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-second tick; counter is held at zero while disabled.
module tick_prescaler #(
    parameter int unsigned TICKS_PER_SEC = 250
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICKS_PER_SEC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = '0;
        if (enable && (cnt_q != CNT_LAST)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/time_set_ctrl.sv
// Button-driven time-set sequencer: captures live time, edits h/m/s in a shadow
// copy, then pulses load for one cycle; also owns the seconds prescaler and blink.
module time_set_ctrl
    import time_ctrl_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 250,
    parameter int unsigned BLINK_HALF    = 125
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn_mode,
    input  logic               btn_inc,
    input  logic [FIELD_W-1:0] cur_secs,
    input  logic [FIELD_W-1:0] cur_mins,
    input  logic [FIELD_W-1:0] cur_hours,
    output logic               sec_tick,
    output logic               load,
    output logic [FIELD_W-1:0] set_secs,
    output logic [FIELD_W-1:0] set_mins,
    output logic [FIELD_W-1:0] set_hours,
    output logic [1:0]         edit_field,
    output logic               blink
);

    localparam int unsigned BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

    state_e             state_q, state_d;
    hms_t               shadow_q, shadow_d;
    logic               blink_q, blink_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               pre_enable;
    logic               pre_tick;

    // Prescaler only runs while staying in RUN, so it restarts from zero after COMMIT.
    assign pre_enable = (state_q == ST_RUN) && !btn_mode;

    tick_prescaler #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .enable(pre_enable),
        .tick  (pre_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            shadow_q    <= '0;
            blink_q     <= 1'b0;
            blink_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            blink_q     <= blink_d;
            blink_cnt_q <= blink_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        blink_d     = 1'b0;
        blink_cnt_d = '0;

        // btn_mode is tested first everywhere so it wins over a coincident btn_inc.
        case (state_q)
            ST_RUN: begin
                if (btn_mode) begin
                    state_d        = ST_SET_H;
                    shadow_d.hours = cur_hours;
                    shadow_d.mins  = cur_mins;
                    shadow_d.secs  = cur_secs;
                end
            end
            ST_SET_H: begin
                if (btn_mode) begin
                    state_d = ST_SET_M;
                end else if (btn_inc) begin
                    shadow_d.hours = inc_wrap(shadow_q.hours, MAX_HOURS);
                end
            end
            ST_SET_M: begin
                if (btn_mode) begin
                    state_d = ST_SET_S;
                end else if (btn_inc) begin
                    shadow_d.mins = inc_wrap(shadow_q.mins, MAX_MINSEC);
                end
            end
            ST_SET_S: begin
                if (btn_mode) begin
                    state_d = ST_COMMIT;
                end else if (btn_inc) begin
                    shadow_d.secs = inc_wrap(shadow_q.secs, MAX_MINSEC);
                end
            end
            ST_COMMIT: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        // Blink restarts lit on edit entry and keeps its phase across field changes.
        if ((state_q == ST_RUN) && (state_d == ST_SET_H)) begin
            blink_d     = 1'b1;
            blink_cnt_d = '0;
        end else if (state_d inside {ST_SET_H, ST_SET_M, ST_SET_S}) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_d     = ~blink_q;
                blink_cnt_d = '0;
            end else begin
                blink_d     = blink_q;
                blink_cnt_d = blink_cnt_q + BLINK_W'(1);
            end
        end
    end

    always_comb begin
        edit_field = FIELD_NONE;
        case (state_q)
            ST_SET_H: edit_field = FIELD_HOURS;
            ST_SET_M: edit_field = FIELD_MINS;
            ST_SET_S: edit_field = FIELD_SECS;
            default:  edit_field = FIELD_NONE;
        endcase
    end

    assign sec_tick  = pre_tick && (state_q == ST_RUN);
    assign load      = (state_q == ST_COMMIT);
    assign set_hours = shadow_q.hours;
    assign set_mins  = shadow_q.mins;
    assign set_secs  = shadow_q.secs;
    assign blink     = blink_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Scoreboard bench for time_set_ctrl: expected tick/load events are queued as
// stimulus is driven and matched when the DUT emits them.
module tb_time_set_ctrl;

    localparam int unsigned TPS = 250;
    localparam int unsigned BH  = 125;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [5:0] cur_secs = '0;
    logic [5:0] cur_mins = '0;
    logic [5:0] cur_hours = '0;
    logic       sec_tick;
    logic       load;
    logic [5:0] set_secs;
    logic [5:0] set_mins;
    logic [5:0] set_hours;
    logic [1:0] edit_field;
    logic       blink;

    typedef struct {
        int cyc;
        int h;
        int m;
        int s;
    } load_exp_t;

    load_exp_t load_q[$];
    int        tick_q[$];
    int        cyc = 0;
    int        n_checks = 0;
    int        n_fail = 0;
    int        c1;

    time_set_ctrl #(
        .TICKS_PER_SEC(TPS),
        .BLINK_HALF   (BH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .cur_secs  (cur_secs),
        .cur_mins  (cur_mins),
        .cur_hours (cur_hours),
        .sec_tick  (sec_tick),
        .load      (load),
        .set_secs  (set_secs),
        .set_mins  (set_mins),
        .set_hours (set_hours),
        .edit_field(edit_field),
        .blink     (blink)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Match DUT-emitted events against the scoreboard queues.
    task automatic observe();
        load_exp_t e;
        if (sec_tick === 1'b1) begin
            if (tick_q.size() == 0) check_eq("unexpected_tick", 32'(sec_tick), 32'd0);
            else check_eq("tick_cycle", cyc, tick_q.pop_front());
        end
        if (load === 1'b1) begin
            if (load_q.size() == 0) begin
                check_eq("unexpected_load", 32'(load), 32'd0);
            end else begin
                e = load_q.pop_front();
                check_eq("load_cycle", cyc, e.cyc);
                check_eq("load_hours", 32'(set_hours), e.h);
                check_eq("load_mins", 32'(set_mins), e.m);
                check_eq("load_secs", 32'(set_secs), e.s);
            end
        end
    endtask

    // One cycle: observe this cycle's outputs, then drive this cycle's inputs.
    task automatic step(input logic r, input logic m, input logic i);
        @(negedge clk);
        cyc++;
        observe();
        reset    = r;
        btn_mode = m;
        btn_inc  = i;
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
    endtask

    task automatic check_set(input string tag, input int h, input int m, input int s);
        check_eq({tag, "_hours"}, 32'(set_hours), h);
        check_eq({tag, "_mins"}, 32'(set_mins), m);
        check_eq({tag, "_secs"}, 32'(set_secs), s);
    endtask

    task automatic check_drained(input string tag);
        check_eq({tag, "_ticks_pending"}, tick_q.size(), 32'd0);
        check_eq({tag, "_loads_pending"}, load_q.size(), 32'd0);
    endtask

    initial begin
        // Free run after reset
        do_reset();
        c1 = cyc + 1;
        tick_q.push_back(c1 + TPS - 1);
        tick_q.push_back(c1 + 2 * TPS - 1);
        tick_q.push_back(c1 + 3 * TPS - 1);
        step(1'b0, 1'b0, 1'b0);
        check_eq("rst_edit_field", 32'(edit_field), 32'd0);
        check_eq("rst_blink", 32'(blink), 32'd0);
        check_eq("rst_load", 32'(load), 32'd0);
        check_eq("rst_sec_tick", 32'(sec_tick), 32'd0);
        check_set("rst_set", 0, 0, 0);
        repeat (760) step(1'b0, 1'b0, 1'b0);
        check_drained("free_run");

        // Full edit 12:34:56 -> 15:35:56
        do_reset();
        cur_hours = 6'd12; cur_mins = 6'd34; cur_secs = 6'd56;
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        check_eq("seth_edit_field", 32'(edit_field), 32'd1);
        check_eq("seth_blink", 32'(blink), 32'd1);
        check_set("capture", 12, 34, 56);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        check_eq("inc_hours", 32'(set_hours), 32'd15);
        step(1'b0, 1'b0, 1'b1);
        check_eq("setm_edit_field", 32'(edit_field), 32'd2);
        step(1'b0, 1'b1, 1'b0);
        check_eq("inc_mins", 32'(set_mins), 32'd35);
        step(1'b0, 1'b1, 1'b0);
        check_eq("sets_edit_field", 32'(edit_field), 32'd3);
        load_q.push_back('{cyc + 1, 15, 35, 56});
        tick_q.push_back(cyc + 1 + TPS);
        step(1'b0, 1'b0, 1'b1);
        check_eq("commit_load", 32'(load), 32'd1);
        check_eq("commit_edit_field", 32'(edit_field), 32'd0);
        check_eq("commit_blink", 32'(blink), 32'd0);
        repeat (3) step(1'b0, 1'b0, 1'b1);
        check_eq("run_edit_field", 32'(edit_field), 32'd0);
        repeat (250) step(1'b0, 1'b0, 1'b0);
        check_set("run_inc_ignored", 15, 35, 56);
        check_drained("full_edit");

        // Wrap from 23:59:59, then out-of-range capture 30:60:63
        do_reset();
        cur_hours = 6'd23; cur_mins = 6'd59; cur_secs = 6'd59;
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        load_q.push_back('{cyc + 1, 0, 0, 0});
        step(1'b0, 1'b0, 1'b0);
        cur_hours = 6'd30; cur_mins = 6'd60; cur_secs = 6'd63;
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        check_eq("capture_hours_30", 32'(set_hours), 32'd30);
        step(1'b0, 1'b1, 1'b0);
        check_eq("wrap_hours_30", 32'(set_hours), 32'd0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        load_q.push_back('{cyc + 1, 0, 0, 0});
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check_drained("wrap");

        // btn_mode and btn_inc together in SET_M
        do_reset();
        cur_hours = 6'd1; cur_mins = 6'd2; cur_secs = 6'd3;
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        check_eq("coll_pre_edit_field", 32'(edit_field), 32'd2);
        step(1'b0, 1'b0, 1'b0);
        check_eq("coll_edit_field", 32'(edit_field), 32'd3);
        check_eq("coll_mins", 32'(set_mins), 32'd2);
        step(1'b0, 1'b1, 1'b0);
        load_q.push_back('{cyc + 1, 1, 2, 3});
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check_drained("collision");

        // Reset in SET_M abandons the edit
        cur_hours = 6'd5; cur_mins = 6'd6; cur_secs = 6'd7;
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check_eq("pre_reset_edit_field", 32'(edit_field), 32'd2);
        c1 = cyc + 1;
        tick_q.push_back(c1 + TPS - 1);
        step(1'b0, 1'b0, 1'b0);
        check_eq("midrst_edit_field", 32'(edit_field), 32'd0);
        check_eq("midrst_load", 32'(load), 32'd0);
        check_eq("midrst_blink", 32'(blink), 32'd0);
        check_set("midrst_set", 0, 0, 0);
        repeat (255) step(1'b0, 1'b0, 1'b0);
        check_drained("reset_mid_edit");

        // btn_mode coincident with sec_tick
        do_reset();
        c1 = cyc + 1;
        tick_q.push_back(c1 + TPS - 1);
        repeat (TPS - 1) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check_eq("mode_on_tick_tick", 32'(sec_tick), 32'd1);
        step(1'b0, 1'b1, 1'b0);
        check_eq("mode_on_tick_edit_field", 32'(edit_field), 32'd1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        load_q.push_back('{cyc + 1, 5, 6, 7});
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check_drained("mode_on_tick");

        // Blink phases in SET_H and return to 0 on COMMIT
        do_reset();
        step(1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= 2 * BH + 1; k++) begin
            step(1'b0, 1'b0, 1'b0);
            check_eq("blink_phase", 32'(blink), (k <= BH) ? 32'd1 : ((k <= 2 * BH) ? 32'd0 : 32'd1));
        end
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        load_q.push_back('{cyc + 1, 5, 6, 7});
        step(1'b0, 1'b0, 1'b0);
        check_eq("blink_commit", 32'(blink), 32'd0);
        check_eq("blink_commit_edit_field", 32'(edit_field), 32'd0);
        step(1'b0, 1'b0, 1'b0);
        check_eq("blink_run", 32'(blink), 32'd0);
        check_drained("blink");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 The block SHALL have parameter TICKS_PER_SEC, default 250, meaning clk cycles per one-second tick.
REQ-002 The block SHALL have parameter BLINK_HALF, default 125, meaning clk cycles per blink half-period.
REQ-003 The block SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port btn_mode  input  1  single-cycle debounced pulse that advances the edit sequence.
REQ-006 The block SHALL have port btn_inc  input  1  single-cycle debounced pulse that increments the field being edited.
REQ-007 The block SHALL have ports cur_secs, cur_mins, cur_hours  input  6 each  live time from the time counter.
REQ-008 The block SHALL have port sec_tick  output  1  one-cycle count-enable pulse to the time counter.
REQ-009 The block SHALL have port load  output  1  one-cycle pulse that loads set_* into the time counter.
REQ-010 The block SHALL have ports set_secs, set_mins, set_hours  output  6 each  shadow values to load.
REQ-011 The block SHALL have port edit_field  output  2  field being edited: 0 none, 1 hours, 2 mins, 3 secs.
REQ-012 The block SHALL have port blink  output  1  display blink for the edited field.

Function
REQ-013 The FSM SHALL have states RUN, SET_H, SET_M, SET_S and COMMIT.
REQ-014 Transitions on btn_mode SHALL be: RUN->SET_H, SET_H->SET_M, SET_M->SET_S, SET_S->COMMIT.
REQ-015 COMMIT SHALL last exactly one cycle and always return to RUN.
REQ-016 On RUN->SET_H, the shadow registers SHALL capture cur_* as sampled in the same cycle btn_mode is high.
REQ-017 In SET_H, btn_inc SHALL increment set_hours, wrapping 23->0; any value >=23 becomes 0.
REQ-018 In SET_M and SET_S, btn_inc SHALL increment set_mins or set_secs respectively, wrapping 59->0; any value >=59 becomes 0.
REQ-019 If btn_mode and btn_inc are high in the same cycle, btn_mode SHALL win and the increment is discarded.
REQ-020 btn_inc in RUN or COMMIT SHALL be ignored.
REQ-021 load SHALL be 1 only during the COMMIT cycle, with set_* stable through that cycle.
REQ-022 Prescaler behaviour SHALL be:
- counts 0..TICKS_PER_SEC-1 only in RUN;
- held at 0 in SET_*/COMMIT.
REQ-023 sec_tick SHALL be high iff state is RUN and the prescaler equals TICKS_PER_SEC-1.
REQ-024 Consequently, sec_tick SHALL occur:
- first on the TICKS_PER_SEC-th cycle after reset release;
- first on the TICKS_PER_SEC-th cycle after COMMIT;
- never while editing.
REQ-025 btn_mode arriving in the same cycle as sec_tick SHALL still move to SET_H; that tick is still emitted.
REQ-026 edit_field SHALL be 1/2/3 in SET_H/SET_M/SET_S and 0 in RUN/COMMIT.
REQ-027 Blink behaviour SHALL be:
- toggles every BLINK_HALF cycles in SET_*;
- forced 0 in RUN/COMMIT;
- blink counter cleared and blink=1 on entry to SET_H.

Reset
REQ-028 While reset is high at a clock edge, the block SHALL go to state RUN with prescaler 0 and blink counter 0.
REQ-029 Reset SHALL clear the shadow registers to 0.
REQ-030 Reset SHALL drive outputs: sec_tick=0, load=0, set_*=0, edit_field=0, blink=0.
REQ-031 Reset asserted mid-edit SHALL abandon the edit with no load pulse.
REQ-032 Reset SHALL take priority over all button inputs.

Structure
REQ-033 Package time_ctrl_pkg SHALL hold:
- state enumeration;
- edit_field codes;
- MAX_HOURS=23, MAX_MINSEC=59;
- field width 6.
REQ-034 The prescaler SHALL be a sub-module tick_prescaler (clk, reset, enable, tick) parameterised by TICKS_PER_SEC.
REQ-035 FSM, shadow registers and blink SHALL reside in time_set_ctrl.

Verification
REQ-036 Free run: release reset, no buttons -> sec_tick on cycles 250, 500 and 750; load never 1.
REQ-037 Full edit: cur=12:34:56; btn_mode; 3x btn_inc in SET_H; 1x in SET_M; 0x in SET_S; btn_mode x3 -> load one cycle with set=15:35:56; next sec_tick 250 cycles later.
REQ-038 Wrap: capture 23:59:59; one btn_inc per field -> set=00:00:00; captured hours=30 -> one btn_inc gives 0.
REQ-039 Collision: btn_mode and btn_inc together in SET_M -> state SET_S, set_mins unchanged.
REQ-040 Reset mid-edit: reset asserted in SET_M -> next cycle RUN, edit_field=0, load=0; sec_tick at 250 cycles after release.
REQ-041 Blink: in SET_H, blink=1 for 125 cycles then 0 for 125; returns to 0 on COMMIT.
